// File: rtl/cdb_arbiter_pkg.sv
// Constants shared by the CDB and its consumers (RS, LSB, RoB), plus the
// round-robin pointer step used by the arbiter.
package cdb_arbiter_pkg;

  localparam int XLEN              = 32;
  localparam int ROB_WIDTH_DEFAULT = 3;

  typedef logic [XLEN-1:0] word_t;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Single-source result FIFO: combinational head, pointer-wrapping storage,
// same-cycle push/pop, flush and synchronous reset.
module cdb_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int WIDTH = ROB_WIDTH_DEFAULT + XLEN,
  parameter int DEPTH = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   en_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = en_i && !flush_i && push_i;
  assign do_pop  = en_i && !flush_i && pop_i;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk_in) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (en_i) begin
      if (flush_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_push) begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
          rd_ptr_q <= rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cdb_arbiter.sv
// Registered common data bus: per-source FIFOs with bypass, round-robin
// winner selection, and one broadcast per cycle to RS, LSB and RoB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int RoB_WIDTH  = ROB_WIDTH_DEFAULT,
  parameter int NUM_SRC    = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush_in,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*RoB_WIDTH-1:0] src_index,
  input  logic [NUM_SRC*XLEN-1:0]      src_data,
  output logic [NUM_SRC-1:0]           src_ready,
  output logic                         cdb_en,
  output logic [RoB_WIDTH-1:0]         cdb_index,
  output logic [XLEN-1:0]              cdb_data
);

  localparam int EW = RoB_WIDTH + XLEN;
  localparam int SW = $clog2(NUM_SRC);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SRC-1:0]   accept;
  logic [NUM_SRC-1:0]   has_head;
  logic [NUM_SRC-1:0]   cand;
  logic [NUM_SRC-1:0]   grant;
  logic [NUM_SRC-1:0]   push;
  logic [NUM_SRC-1:0]   pop;
  logic [EW-1:0]        head       [NUM_SRC];
  logic [EW-1:0]        cand_entry [NUM_SRC];
  logic [CW-1:0]        count      [NUM_SRC];

  logic [SW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 win_valid;
  logic [EW-1:0]        win_entry;
  logic                 cdb_en_q;
  logic [RoB_WIDTH-1:0] cdb_index_q;
  word_t                cdb_data_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign src_ready[gi]  = count[gi] < CW'(FIFO_DEPTH);
      assign accept[gi]     = src_valid[gi] && src_ready[gi] && rdy_in && !flush_in && !rst_in;
      assign has_head[gi]   = count[gi] != '0;
      // A queued head always outranks the new arrival to keep per-source order.
      assign cand_entry[gi] = has_head[gi] ? head[gi]
                            : {src_index[gi*RoB_WIDTH +: RoB_WIDTH], src_data[gi*XLEN +: XLEN]};
      assign cand[gi]       = has_head[gi] || accept[gi];
      assign pop[gi]        = grant[gi] && has_head[gi];
      assign push[gi]       = accept[gi] && !(grant[gi] && !has_head[gi]);

      cdb_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .en_i    (rdy_in),
        .flush_i (flush_in),
        .push_i  (push[gi]),
        .pop_i   (pop[gi]),
        .din_i   ({src_index[gi*RoB_WIDTH +: RoB_WIDTH], src_data[gi*XLEN +: XLEN]}),
        .head_o  (head[gi]),
        .count_o (count[gi])
      );
    end
  endgenerate

  always_comb begin
    int            idx;
    logic [SW-1:0] sel;
    idx       = 0;
    sel       = '0;
    grant     = '0;
    win_valid = 1'b0;
    win_entry = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end
      sel = SW'(idx);
      if (!win_valid && cand[sel]) begin
        win_valid  = 1'b1;
        grant[sel] = 1'b1;
        win_entry  = cand_entry[sel];
        rr_ptr_d   = SW'(rr_next(idx, NUM_SRC));
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr_q    <= '0;
      cdb_en_q    <= 1'b0;
      cdb_index_q <= '0;
      cdb_data_q  <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        rr_ptr_q <= '0;
        cdb_en_q <= 1'b0;
      end else begin
        rr_ptr_q <= rr_ptr_d;
        cdb_en_q <= win_valid;
        if (win_valid) begin
          {cdb_index_q, cdb_data_q} <= win_entry;
        end
      end
    end
  end

  assign cdb_en    = cdb_en_q;
  assign cdb_index = cdb_index_q;
  assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scenario bench for cdb_arbiter (3 sources, depth 2): per-source expected
// queues are filled on accept and drained as results appear on the bus.
module tb_cdb_arbiter;

  localparam int NS    = 3;
  localparam int DEPTH = 2;
  localparam int RW    = 3;
  localparam int EW    = RW + 32;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             rdy_in;
  logic             flush_in;
  logic [NS-1:0]    src_valid;
  logic [NS*RW-1:0] src_index;
  logic [NS*32-1:0] src_data;
  logic [NS-1:0]    src_ready;
  logic             cdb_en;
  logic [RW-1:0]    cdb_index;
  logic [31:0]      cdb_data;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [RW-1:0] cur_idx  [NS];
  logic [31:0]   cur_data [NS];
  int            seq      [NS];
  logic [EW-1:0] sb_q     [NS][$];

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(
    .RoB_WIDTH  (RW),
    .NUM_SRC    (NS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush_in  (flush_in),
    .src_valid (src_valid),
    .src_index (src_index),
    .src_data  (src_data),
    .src_ready (src_ready),
    .cdb_en    (cdb_en),
    .cdb_index (cdb_index),
    .cdb_data  (cdb_data)
  );

  // Generic items tag their source in data[31:24] so the bench can route them.
  task automatic next_item(input int i);
    cur_data[i] = {8'(i), 24'(seq[i])};
    cur_idx[i]  = RW'(seq[i] * 3 + i);
  endtask

  task automatic sb_clear();
    for (int i = 0; i < NS; i++) sb_q[i].delete();
  endtask

  function automatic int sb_total();
    int t;
    t = 0;
    for (int i = 0; i < NS; i++) t += sb_q[i].size();
    return t;
  endfunction

  function automatic logic [EW-1:0] sb_pop(input int s, output bit ok);
    ok = 1'b0;
    sb_pop = '0;
    if (s >= 0 && s < NS && sb_q[s].size() > 0) begin
      ok = 1'b1;
      sb_pop = sb_q[s].pop_front();
    end
  endfunction

  // One clock: drive, let the DUT sample, record accepted items as expected.
  task automatic step(input logic [NS-1:0] v, input logic rdy, input logic fl);
    logic [NS-1:0] acc;
    src_valid = v;
    rdy_in    = rdy;
    flush_in  = fl;
    for (int i = 0; i < NS; i++) begin
      src_index[i*RW +: RW] = cur_idx[i];
      src_data[i*32 +: 32]  = cur_data[i];
    end
    acc = v & src_ready & {NS{rdy & ~fl}};
    @(posedge clk_in);
    #1;
    if (rdy && fl) sb_clear();
    for (int i = 0; i < NS; i++) begin
      if (acc[i]) begin
        sb_q[i].push_back({cur_idx[i], cur_data[i]});
        seq[i]++;
        next_item(i);
      end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; src_valid = '0;
    repeat (2) @(posedge clk_in);
    #1;
    n_cmp++;
    if (cdb_en !== 1'b0 || cdb_index !== '0 || cdb_data !== '0) begin
      n_fail++;
      $display("FAIL reset_cdb: got en=%b idx=%0d data=%h expected en=0 idx=0 data=0", cdb_en, cdb_index, cdb_data);
    end
    n_cmp++;
    if (src_ready !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 111", src_ready);
    end
    rst_in = 1'b0;
    sb_clear();
    $display("test_reset done");
  endtask

  task automatic test_single();
    step(3'b000, 1'b1, 1'b0);
    step(3'b000, 1'b1, 1'b0);
    cur_idx[0] = 3'd5; cur_data[0] = 32'hDEADBEEF;
    step(3'b001, 1'b1, 1'b0);
    n_cmp++;
    if (cdb_en !== 1'b1 || cdb_index !== 3'd5 || cdb_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_bcast: got en=%b idx=%0d data=%h expected en=1 idx=5 data=deadbeef", cdb_en, cdb_index, cdb_data);
    end
    step(3'b000, 1'b1, 1'b0);
    n_cmp++;
    if (cdb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL single_once: got en=%b expected 0", cdb_en);
    end
    sb_clear();
    $display("test_single done");
  endtask

  task automatic test_conflict();
    step(3'b000, 1'b1, 1'b1);
    cur_idx[0] = 3'd1; cur_data[0] = 32'h11;
    cur_idx[1] = 3'd2; cur_data[1] = 32'h22;
    step(3'b011, 1'b1, 1'b0);
    n_cmp++;
    if (cdb_en !== 1'b1 || cdb_index !== 3'd1 || cdb_data !== 32'h11) begin
      n_fail++;
      $display("FAIL conflict_first: got en=%b idx=%0d data=%h expected en=1 idx=1 data=11", cdb_en, cdb_index, cdb_data);
    end
    step(3'b000, 1'b1, 1'b0);
    n_cmp++;
    if (cdb_en !== 1'b1 || cdb_index !== 3'd2 || cdb_data !== 32'h22) begin
      n_fail++;
      $display("FAIL conflict_second: got en=%b idx=%0d data=%h expected en=1 idx=2 data=22", cdb_en, cdb_index, cdb_data);
    end
    step(3'b000, 1'b1, 1'b0);
    n_cmp++;
    if (cdb_en !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_idle: got en=%b expected 0", cdb_en);
    end
    sb_clear();
    $display("test_conflict done");
  endtask

  task automatic test_fairness();
    int g0, g1, k, s;
    bit ok;
    logic [EW-1:0] exp;
    g0 = 0; g1 = 0; k = 0;
    step(3'b000, 1'b1, 1'b1);
    for (int c = 0; c < 14; c++) begin
      step((c < 6) ? 3'b011 : 3'b000, 1'b1, 1'b0);
      if (cdb_en) begin
        s = int'(cdb_data[31:24]);
        exp = sb_pop(s, ok);
        n_cmp++;
        if (!ok || {cdb_index, cdb_data} !== exp) begin
          n_fail++;
          $display("FAIL fair_order: got idx=%0d data=%h expected idx=%0d data=%h (ok=%0d)", cdb_index, cdb_data, exp[EW-1 -: RW], exp[31:0], ok);
        end
        if (k < 6) begin
          n_cmp++;
          if (s != k % 2) begin
            n_fail++;
            $display("FAIL fair_turn: grant %0d got src %0d expected src %0d", k, s, k % 2);
          end
          if (s == 0) g0++;
          if (s == 1) g1++;
        end
        k++;
      end
    end
    n_cmp++;
    if (g0 != 3 || g1 != 3) begin
      n_fail++;
      $display("FAIL fair_count: got src0=%0d src1=%0d expected 3 and 3", g0, g1);
    end
    n_cmp++;
    if (sb_total() != 0) begin
      n_fail++;
      $display("FAIL fair_lost: got %0d undelivered expected 0", sb_total());
    end
    $display("test_fairness done: %0d broadcasts", k);
  endtask

  task automatic test_backpressure();
    int s, lows;
    bit ok;
    logic [EW-1:0] exp;
    lows = 0;
    step(3'b000, 1'b1, 1'b1);
    for (int c = 0; c < 30; c++) begin
      step((c < 15) ? 3'b111 : 3'b000, 1'b1, 1'b0);
      if (cdb_en) begin
        s = int'(cdb_data[31:24]);
        exp = sb_pop(s, ok);
        n_cmp++;
        if (!ok || {cdb_index, cdb_data} !== exp) begin
          n_fail++;
          $display("FAIL bp_order: got idx=%0d data=%h expected idx=%0d data=%h (ok=%0d)", cdb_index, cdb_data, exp[EW-1 -: RW], exp[31:0], ok);
        end
      end
      for (int i = 0; i < NS; i++) begin
        n_cmp++;
        if (src_ready[i] !== (sb_q[i].size() < DEPTH)) begin
          n_fail++;
          $display("FAIL bp_ready: cycle %0d src %0d got %b expected %b", c, i, src_ready[i], sb_q[i].size() < DEPTH);
        end
      end
      if (src_ready != 3'b111) lows++;
    end
    n_cmp++;
    if (lows == 0) begin
      n_fail++;
      $display("FAIL bp_full: got 0 cycles with src_ready low expected at least 1");
    end
    n_cmp++;
    if (sb_total() != 0) begin
      n_fail++;
      $display("FAIL bp_lost: got %0d undelivered expected 0", sb_total());
    end
    $display("test_backpressure done: %0d backpressured cycles", lows);
  endtask

  task automatic test_flush();
    int s;
    bit ok;
    logic [EW-1:0] exp;
    step(3'b000, 1'b1, 1'b1);
    step(3'b110, 1'b1, 1'b0);
    step(3'b011, 1'b1, 1'b0);
    step(3'b010, 1'b1, 1'b0);
    n_cmp++;
    if (src_ready[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_setup: src1 ready got %b expected 0", src_ready[1]);
    end
    step(3'b111, 1'b1, 1'b1);
    n_cmp++;
    if (cdb_en !== 1'b0 || src_ready !== 3'b111) begin
      n_fail++;
      $display("FAIL flush_state: got en=%b ready=%b expected en=0 ready=111", cdb_en, src_ready);
    end
    for (int c = 0; c < 5; c++) begin
      step(3'b000, 1'b1, 1'b0);
      n_cmp++;
      if (cdb_en !== 1'b0) begin
        s = int'(cdb_data[31:24]);
        exp = sb_pop(s, ok);
        n_fail++;
        $display("FAIL flush_leak: got en=1 idx=%0d data=%h expected en=0", cdb_index, cdb_data);
      end
    end
    $display("test_flush done");
  endtask

  task automatic test_hold();
    int s;
    bit ok;
    logic [EW-1:0] exp, held;
    step(3'b000, 1'b1, 1'b1);
    step(3'b011, 1'b1, 1'b0);
    held = sb_pop(0, ok);
    n_cmp++;
    if (!ok || cdb_en !== 1'b1 || {cdb_index, cdb_data} !== held) begin
      n_fail++;
      $display("FAIL hold_first: got en=%b idx=%0d data=%h expected en=1 idx=%0d data=%h", cdb_en, cdb_index, cdb_data, held[EW-1 -: RW], held[31:0]);
    end
    for (int c = 0; c < 3; c++) begin
      step(3'b011, 1'b0, 1'b0);
      n_cmp++;
      if (cdb_en !== 1'b1 || {cdb_index, cdb_data} !== held || src_ready !== 3'b111) begin
        n_fail++;
        $display("FAIL hold_frozen: cycle %0d got en=%b idx=%0d data=%h ready=%b expected en=1 idx=%0d data=%h ready=111", c, cdb_en, cdb_index, cdb_data, src_ready, held[EW-1 -: RW], held[31:0]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      step(3'b000, 1'b1, 1'b0);
      if (cdb_en) begin
        s = int'(cdb_data[31:24]);
        exp = sb_pop(s, ok);
        n_cmp++;
        if (!ok || s != 1 || {cdb_index, cdb_data} !== exp) begin
          n_fail++;
          $display("FAIL hold_resume: got idx=%0d data=%h expected src1 idx=%0d data=%h (ok=%0d)", cdb_index, cdb_data, exp[EW-1 -: RW], exp[31:0], ok);
        end
      end
    end
    n_cmp++;
    if (sb_total() != 0) begin
      n_fail++;
      $display("FAIL hold_lost: got %0d undelivered expected 0", sb_total());
    end
    $display("test_hold done");
  endtask

  task automatic test_reset_mid();
    step(3'b000, 1'b1, 1'b1);
    step(3'b111, 1'b1, 1'b0);
    step(3'b111, 1'b1, 1'b0);
    rst_in = 1'b1;
    src_valid = 3'b111;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    src_valid = '0;
    sb_clear();
    n_cmp++;
    if (cdb_en !== 1'b0 || cdb_index !== '0 || cdb_data !== '0 || src_ready !== 3'b111) begin
      n_fail++;
      $display("FAIL rstmid_state: got en=%b idx=%0d data=%h ready=%b expected 0/0/0/111", cdb_en, cdb_index, cdb_data, src_ready);
    end
    for (int c = 0; c < 4; c++) begin
      step(3'b000, 1'b1, 1'b0);
      n_cmp++;
      if (cdb_en !== 1'b0) begin
        n_fail++;
        $display("FAIL rstmid_leak: got en=1 idx=%0d data=%h expected en=0", cdb_index, cdb_data);
      end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0;
    src_valid = '0; src_index = '0; src_data = '0;
    for (int i = 0; i < NS; i++) begin
      seq[i] = 0;
      next_item(i);
    end
    test_reset();
    test_single();
    test_conflict();
    test_fairness();
    test_backpressure();
    test_flush();
    test_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Parametrised, registered common data bus (CDB) for the out-of-order core. It collects `[RoBIndex, Value]` results from `NUM_SRC` producers (RS/ALU, LSB, future units) and broadcasts one result per cycle to RS, LSB and RoB. Simultaneous results are never lost: per-source FIFOs buffer losers, a round-robin arbiter picks the winner, and a flush clears all in-flight results.

## Interface
- `RoB_WIDTH`, 3, RoB index width
- `NUM_SRC`, 2, number of producers (≥2)
- `FIFO_DEPTH`, 2, entries per source FIFO (power of two, ≥2)
- `clk_in`  input  1  clock
- `rst_in`  input  1  reset; one clock; reset is synchronous and active-high
- `rdy_in`  input  1  global enable; low = hold all state
- `flush_in`  input  1  misprediction flush
- `src_valid`  input  NUM_SRC  producer i offers a result
- `src_index`  input  NUM_SRC*RoB_WIDTH  producer i RoB index at `[i*RoB_WIDTH +: RoB_WIDTH]`
- `src_data`  input  NUM_SRC*32  producer i value at `[i*32 +: 32]`
- `src_ready`  output  NUM_SRC  FIFO i not full
- `cdb_en`  output  1  broadcast valid
- `cdb_index`  output  RoB_WIDTH  broadcast RoB index
- `cdb_data`  output  32  broadcast value

## Operation
- Accept for source i: `src_valid[i] && src_ready[i] && rdy_in && !flush_in && !rst_in`. The producer holds valid/index/data stable until accepted.
- `src_ready[i] = (count[i] < FIFO_DEPTH)`. It depends only on registered state, so there is no combinational path from inputs.
- Candidate for source i:
  - FIFO head, if `count[i] > 0`.
  - Otherwise the accepted incoming result (bypass).
  - Otherwise none.
- Round-robin arbitration: the search starts at `rr_ptr` and increments mod NUM_SRC. The first candidate wins. On a grant to i, `rr_ptr <= (i+1) mod NUM_SRC`. With no grant, `rr_ptr` holds.
- Winner is registered into `cdb_*` with `cdb_en <= 1`. With no candidate, `cdb_en <= 0` and `cdb_index`/`cdb_data` hold their old values.
- If the winner is a FIFO head, pop it. Each accepted incoming result that was not bypassed to the bus is pushed to its FIFO tail. Push and pop on the same FIFO in the same cycle are legal, and `count` is unchanged.
- Per-source order is FIFO-preserved. Order across sources follows arbitration only.
- Flush (`flush_in=1` at an edge, with `rdy_in=1`):
  - All FIFOs are emptied (pointers and counts go to 0).
  - `cdb_en <= 0`.
  - `rr_ptr <= 0`.
  - Same-cycle inputs are dropped.
- `rdy_in=0` (and no reset): no register changes and no accepts. `cdb_*` hold their values; consumers apply the same `rdy_in` gating.
- Reset, which overrides flush and `rdy_in`:
  - `cdb_en=0`, `cdb_index=0`, `cdb_data=0`.
  - All counts and pointers are 0, so `src_ready` is all ones.
  - `rr_ptr=0`.
  - Reset mid-operation discards all queued results.

## Timing
- Latency: a result accepted in cycle t, at best, has `cdb_en` high during cycle t+1. A queued result appears k cycles later, where k is its arbitration wait.
- Each broadcast lasts exactly one cycle per result. There are no duplicates.
- Throughput: one result per cycle total.
- `src_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after a pop.
- Pointer wrap: the read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap naturally. `count` is `$clog2(FIFO_DEPTH)+1` bits.
- Full with simultaneous pop and push: legal, and `count` stays at DEPTH. `src_ready` was 0, however, so a push cannot occur that cycle. Only the pop occurs, and `count` becomes DEPTH-1.

## Structure
- Sub-module `cdb_fifo`: a single-source synchronous FIFO of `{RoB_WIDTH+32}`-bit entries with push, pop, head, count, flush and reset. It is instantiated NUM_SRC times via generate.
- The arbiter, bypass mux and output registers live in `cdb_arbiter`.
- Shared constants header: `XLEN=32` and the default `RoB_WIDTH`. These are common with RS, LSB and RoB.

## Test plan
- Single source: src0 offers idx 5, data 0xDEADBEEF in cycle 3. Required: cdb_en=1, idx 5, data 0xDEADBEEF in cycle 4 only, and cdb_en=0 in cycle 5.
- Conflict: with rr_ptr=0, src0 offers (1, 0x11) and src1 offers (2, 0x22) in the same cycle t. Required: cycle t+1 broadcasts idx 1, cycle t+2 broadcasts idx 2, and nothing is lost.
- Fairness: both sources are valid for 6 consecutive cycles with distinct indices. Required: the grants alternate src0, src1, …, giving 3 grants each, and each source's values appear in issue order.
- Backpressure: with FIFO_DEPTH=2, NUM_SRC=3, all sources continuously valid. Required: `src_ready` deasserts when a FIFO is full, every accepted result is broadcast exactly once, and per-source order is intact.
- Flush: with 2 results queued in src1, assert flush_in for one cycle. Required: cdb_en=0 in the next cycle, all src_ready=1, and neither queued result is ever broadcast.
- Hold/reset:
  - Drive rdy_in=0 for 3 cycles with a result pending. Required: cdb_* are frozen and no accepts occur; after rdy_in=1, the pending result broadcasts once.
  - Assert rst_in mid-queue. Required: cdb_en=0, idx 0, data 0, and all queues are empty.
